// File: rtl/seqdet_param_if.sv
// Bus bundle for seqdet_param: serial input, pattern load, match pulse and counter.
// The master side drives the stream; the slave side is the detector.
interface seqdet_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_vld;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din, din_vld, pat_load, pat_in, overlap,
    input  dout, match_cnt
  );

  modport slave (
    input  din, din_vld, pat_load, pat_in, overlap,
    output dout, match_cnt
  );
endinterface

// File: rtl/seqdet_param.sv
// Parametrised serial pattern detector with runtime pattern load and overlap select.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seqdet_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  seqdet_param_if.slave  bus
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] LAST  = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t            state, state_d;
  logic [PAT_W-1:0]  pat_reg, pat_d;
  logic [PAT_W-2:0]  hist, hist_d;
  logic [FILL_W-1:0] fill, fill_d;
  logic              dout_q, dout_d;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              match;

  // The newest bit completes the window in the same cycle it is sampled.
  assign window = {hist, bus.din};
  assign hit    = (window == pat_reg);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    pat_d   = pat_reg;
    hist_d  = hist;
    fill_d  = fill;
    dout_d  = 1'b0;
    match   = 1'b0;

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = IDLE;
    end else if (bus.din_vld) begin
      hist_d = window[PAT_W-2:0];
      unique case (state)
        IDLE: begin
          fill_d  = FILL_W'(1);
          state_d = FILL;
        end
        FILL: begin
          if (fill == LAST) begin
            match   = hit;
            fill_d  = FILL_W'(PAT_W);
            state_d = HUNT;
          end else begin
            fill_d = fill + FILL_W'(1);
          end
        end
        HUNT:    match   = hit;
        default: state_d = IDLE;
      endcase

      // Without overlap a match discards all history, so the next hit needs PAT_W fresh bits.
      if (match) begin
        dout_d = 1'b1;
        if (!bus.overlap) begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = IDLE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_reg <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      dout_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pat_reg <= pat_d;
      hist    <= hist_d;
      fill    <= fill_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.dout = dout_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (bus.pat_load) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seqdet_param.sv
// Randomised self-checking bench for seqdet_param against a queue-based model of the detection rules.
// Counter expectations follow SEQDET_COUNT_EN, so the bench suits either build.
module tb_seqdet_param;

  localparam int               PAT_W   = 4;
  localparam int               CNT_W   = 2;
  localparam logic [PAT_W-1:0] PAT_RST = 4'b1011;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seqdet_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seqdet_param #(
    .PAT_W  (PAT_W),
    .PAT_RST(PAT_RST),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: bits received since the last restart, newest at the back.
  bit               m_bits[$];
  logic [PAT_W-1:0] m_pat;
  int               m_cnt;
  logic             m_dout;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PAT_W-1:0] recent_bits();
    logic [PAT_W-1:0] v = '0;
    foreach (m_bits[i]) v = {v[PAT_W-2:0], m_bits[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pat  = PAT_RST;
    m_cnt  = 0;
    m_dout = 1'b0;
  endtask

  task automatic model_edge(input logic d, input logic v, input logic l,
                            input logic [PAT_W-1:0] p, input logic ov);
    m_dout = 1'b0;
    if (l) begin
      m_pat = p;
      m_bits.delete();
      m_cnt = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_W && recent_bits() == m_pat) begin
        m_dout = 1'b1;
`ifdef SEQDET_COUNT_EN
        if (m_cnt < CNT_MAX) m_cnt++;
`endif
        if (!ov) m_bits.delete();
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then compare just after the edge.
  task automatic step(input logic d, input logic v, input logic l,
                      input logic [PAT_W-1:0] p, input logic ov);
    bus.din      = d;
    bus.din_vld  = v;
    bus.pat_load = l;
    bus.pat_in   = p;
    bus.overlap  = ov;
    @(posedge clk);
    model_edge(d, v, l, p, ov);
    #1;
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
    if (bus.dout === 1'b1) pulses++;
  endtask

  task automatic send(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, '0, ov);
  endtask

  task automatic restart(input logic [PAT_W-1:0] p);
    step(1'b0, 1'b0, 1'b1, p, 1'b1);
    pulses = 0;
  endtask

  initial begin
    bus.din      = 1'b0;
    bus.din_vld  = 1'b0;
    bus.pat_load = 1'b0;
    bus.pat_in   = '0;
    bus.overlap  = 1'b1;
    rst          = 1'b0;
    model_reset();
    #2;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping detection of 1011 in 1011011.
    pulses = 0;
    send(16'b1011011, 7, 1'b1);
    check("ovl_pulses", pulses, 32'd2);

    // Same stream without overlap: history restarts after the first hit.
    restart(4'b1011);
    send(16'b1011011, 7, 1'b0);
    check("novl_pulses", pulses, 32'd1);

    // Three idle cycles between valid bits must not disturb detection.
    restart(4'b1011);
    for (int i = 3; i >= 0; i--) begin
      step(PAT_RST[i], 1'b1, 1'b0, '0, 1'b1);
      repeat (3) step(1'($urandom), 1'b0, 1'b0, '0, 1'b1);
    end
    check("gap_pulses", pulses, 32'd1);

    // A pattern load discards the partial prefix and takes effect for the following bits.
    restart(4'b1011);
    send(16'b101, 3, 1'b1);
    restart(4'b0110);
    send(16'b0110, 4, 1'b1);
    check("load_pulses", pulses, 32'd1);
    pulses = 0;
    send(16'b1011, 4, 1'b1);
    check("old_pat_pulses", pulses, 32'd0);

    // Asynchronous reset mid-stream with a non-zero counter and a changed pattern.
    restart(4'b1011);
    send(16'b1011, 4, 1'b0);
    send(16'b101, 3, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_dout", 32'(bus.dout), 32'd0);
    check("async_rst_cnt", 32'(bus.match_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("hold_rst_dout", 32'(bus.dout), 32'd0);
    check("hold_rst_cnt", 32'(bus.match_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    send(16'b1, 1, 1'b1);
    check("post_rst_pulses", pulses, 32'd0);

    // Five overlapping hits of the reset pattern walk the 2-bit counter into saturation.
    send(16'b011011011011011, 15, 1'b1);
    check("cnt_pulses", pulses, 32'd5);
`ifdef SEQDET_COUNT_EN
    check("cnt_sat", 32'(bus.match_cnt), 32'(CNT_MAX));
`else
    check("cnt_tied", 32'(bus.match_cnt), 32'd0);
`endif

    // Random traffic: sparse valids, occasional loads, overlap toggling per bit.
    for (int i = 0; i < 3000; i++) begin
      logic             v, l, ov, d;
      logic [PAT_W-1:0] p;
      d  = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 59) == 0);
      p  = PAT_W'($urandom);
      ov = ($urandom_range(0, 3) != 0);
      step(d, v, l, p, ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seqdet_param.md
# seqdet_param

Parametrised serial pattern detector. It samples a qualified one-bit stream, compares a sliding window against a runtime-loadable pattern of PAT_W bits, and raises a one-cycle registered match pulse. Overlapping or non-overlapping detection is selectable at run time, and an optional saturating match counter can be compiled in. It sits on serial control and framing paths where the fixed 4-bit detectors were used, and replaces them.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_RST, 4'b1011, pattern value loaded at reset; width PAT_W; MSB is the first bit received.
- CNT_W, 8, width of match_cnt; must be at least 1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- din  input  1  serial data bit.
- din_vld  input  1  din is sampled only when this is high.
- pat_load  input  1  load pat_in as the new pattern and restart detection.
- pat_in  input  PAT_W  new pattern; MSB is the first bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- dout  output  1  match pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- Registers:
  - pat_reg (PAT_W): holds the current pattern.
  - hist (PAT_W-1): holds the last bits received.
  - fill (0..PAT_W): counts valid history bits.
  - state: one of IDLE, FILL or HUNT.
- The window is {hist, din}. Compare it with pat_reg.
- State machine:
  - IDLE: reset state, with fill=0. On din_vld, go to FILL (or to HUNT if PAT_W==1 would apply; not legal).
  - FILL: while fill<PAT_W-1, each din_vld shifts din into hist and increments fill. When the valid bit arrives with fill==PAT_W-1, evaluate the match and go to HUNT.
  - HUNT: compare the window on every din_vld.
    - Match with overlap=1: stay in HUNT. History is kept, so a suffix of the match can start the next one.
    - Match with overlap=0: clear hist, set fill=0, go to IDLE. The next match needs PAT_W fresh bits.
    - No match: shift and stay in HUNT.
- Match: dout<=1 for exactly one cycle; otherwise dout<=0. A matching bit arriving on consecutive valid cycles gives back-to-back pulses. For example, pattern 1111 with overlap=1 on the stream 11111 gives 2 pulses.
- din_vld=0: no state, hist or fill change, and dout<=0.
- pat_load=1 has priority over din_vld. It sets pat_reg<=pat_in, clears hist, fill and dout, sets state=IDLE, and clears match_cnt. din is ignored in that cycle.
- overlap is sampled at the edge where the match is evaluated.
- Reset values: state=IDLE, pat_reg=PAT_RST, hist=0, fill=0, dout=0, match_cnt=0.

## Timing
- Latency: dout goes high in the cycle after the rising edge that samples the final pattern bit (Moore-style, registered).
- match_cnt updates on the same edge that sets dout.
- A pattern loaded at edge k takes effect for bits sampled from edge k+1 onward.
- Asserting rst mid-stream immediately clears all registers, asynchronously. Partial matches are lost. Release is synchronous to the next clk edge, and detection restarts from IDLE.
- There is no combinational path from any input to any output.

## Configuration
- SEQDET_COUNT_EN defined: match_cnt increments by 1 on every match and saturates at all-ones, holding there until reset or pat_load.
- SEQDET_COUNT_EN undefined: the counter logic is removed. The match_cnt port remains and is tied to 0. All other behaviour is identical.

## Test plan
- Defaults, overlap=1, din_vld=1, stream 1,0,1,1,0,1,1: dout pulses once after bit 4 and once after bit 7; match_cnt=2.
- Same stream with overlap=0: one pulse, after bit 4 only; match_cnt=1.
- Stream 1,0,1,1 with din_vld=0 for 3 cycles between each bit: one pulse after the 4th valid bit; no dout change during the gaps.
- pat_load with pat_in=4'b0110 after a partial 1,0,1, then stream 0,1,1,0: the old prefix is discarded and one pulse follows the 4th bit. The stream 1,0,1,1 then gives no pulse.
- Reset mid-stream: send 1,0,1, assert rst for 1 cycle, then send 1. No pulse, and all outputs read 0 during reset.
- CNT_W=2 with SEQDET_COUNT_EN, 5 matches: match_cnt reads 1, 2, 3, 3, 3. Without the macro, match_cnt stays at 0 throughout.
